// File: rtl/fir_pkg.sv
// Shared constants and the round/saturate helper for the FIR datapath.
//
// Contents:
//   FIR_X_W / FIR_Y_W    : filter input sample width / filter output sample width
//   FIR_X_MAX / FIR_X_MIN: representable range of a FIR_X_W-bit sample
//   FIR_CALC_W           : widest input sample sat_round() accepts
//   sat_round()          : round-half-up arithmetic right shift, then saturate
package fir_pkg;

  localparam int unsigned FIR_X_W    = 12;
  localparam int unsigned FIR_Y_W    = 32;
  localparam int unsigned FIR_CALC_W = 64;

  localparam int FIR_X_MAX = (1 << (FIR_X_W - 1)) - 1;
  localparam int FIR_X_MIN = -(1 << (FIR_X_W - 1));

  typedef struct packed {
    logic [FIR_CALC_W-1:0] data;  // saturated result, valid in the low out_w bits
    logic                  sat;   // result was clipped
  } sat_res_t;

  // value must already be sign-extended to FIR_CALC_W. One guard bit above FIR_CALC_W
  // keeps the rounding add from overflowing.
  function automatic sat_res_t sat_round(input logic signed [FIR_CALC_W-1:0] value,
                                         input int unsigned                  shift,
                                         input int unsigned                  out_w);
    logic signed [FIR_CALC_W:0] one;
    logic signed [FIR_CALC_W:0] t;
    logic signed [FIR_CALC_W:0] r;
    logic signed [FIR_CALC_W:0] hi;
    logic signed [FIR_CALC_W:0] lo;
    sat_res_t                   res;

    one = '0;
    one[0] = 1'b1;
    t = {value[FIR_CALC_W-1], value};
    if (shift > 0) begin
      t = t + (one <<< (shift - 1));
    end
    r  = t >>> shift;
    hi = (one <<< (out_w - 1)) - one;
    lo = -hi - one;

    if (r > hi) begin
      res.data = hi[FIR_CALC_W-1:0];
      res.sat  = 1'b1;
    end else if (r < lo) begin
      res.data = lo[FIR_CALC_W-1:0];
      res.sat  = 1'b1;
    end else begin
      res.data = r[FIR_CALC_W-1:0];
      res.sat  = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// Plain synchronous FIFO, asynchronous active-low reset.
//
// Ports:
//   clk, nreset  : clock / async active-low reset
//   push, wdata  : write request and data (accepted when not full, or when full with a pop)
//   pop          : read request (ignored when empty)
//   rdata        : head entry (first-word fall-through)
//   full, empty  : occupancy flags
//   count        : number of stored entries
module fir_sync_fifo import fir_pkg::*; #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 3
) (
  input  logic                         clk,
  input  logic                         nreset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(DEPTH - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign count   = count_q;
  assign rdata   = mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is readable until count says so.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fir_out_requant.sv
// FIR back end: round-half-up arithmetic right shift by SHIFT, saturate to OUT_W bits,
// buffer through a one-stage pipeline register plus a (DEPTH-1)-entry FIFO, and deliver
// on a valid/ready stream. A sticky flag records clipping.
//
// Optional build macro FIR_REQ_SAT_CNT_EN adds sat_cnt, a 16-bit saturating count of
// clipped samples, cleared by clr_sat.
//
// Ports:
//   clk, nreset          : clock / async active-low reset
//   in_valid/in_ready    : input handshake; in_data is the signed IN_W-bit FIR sample
//   out_valid/out_ready  : output handshake; out_data is the signed OUT_W-bit result
//   level                : pipeline register + FIFO occupancy
//   sat_flag, clr_sat    : sticky clip flag and its synchronous clear
//   sat_cnt              : clip counter (FIR_REQ_SAT_CNT_EN only)
module fir_out_requant import fir_pkg::*; #(
  parameter int unsigned IN_W  = FIR_Y_W,
  parameter int unsigned OUT_W = FIR_X_W,
  parameter int unsigned SHIFT = 7,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       nreset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IN_W-1:0]            in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       sat_flag,
`ifdef FIR_REQ_SAT_CNT_EN
  output logic [15:0]                sat_cnt,
`endif
  input  logic                       clr_sat
);

  localparam int unsigned LevelW    = $clog2(DEPTH) + 1;
  localparam int unsigned FifoDepth = DEPTH - 1;
  localparam int unsigned FifoCntW  = $clog2(FifoDepth + 1);

  logic             ready_en_q;
  logic             pipe_valid_q, pipe_valid_d;
  logic [OUT_W-1:0] pipe_data_q, pipe_data_d;
  logic             sat_flag_q, sat_flag_d;

  logic                push, pop, sat_set;
  logic                fifo_push, fifo_full, fifo_empty;
  logic [OUT_W-1:0]    fifo_rdata;
  logic [FifoCntW-1:0] fifo_count;
  sat_res_t            res;
  logic [OUT_W-1:0]    res_data;
  logic                unused_res_hi;

  assign res      = sat_round(FIR_CALC_W'(signed'(in_data)), SHIFT, OUT_W);
  assign res_data = res.data[OUT_W-1:0];
  assign unused_res_hi = ^res.data[FIR_CALC_W-1:OUT_W];

  assign level = LevelW'(pipe_valid_q) + LevelW'(fifo_count);
  // Depends on state only, so a pop on a full edge cannot open room for a push.
  // ready_en_q keeps in_ready low during reset and until the first edge after it.
  assign in_ready  = ready_en_q && (level < LevelW'(DEPTH));
  assign out_valid = !fifo_empty;
  assign out_data  = out_valid ? fifo_rdata : '0;

  assign push    = in_valid && in_ready;
  assign pop     = out_valid && out_ready;
  assign sat_set = push && res.sat;
  // When the FIFO is full the pipeline sample waits until a pop frees an entry.
  assign fifo_push = pipe_valid_q && (!fifo_full || pop);

  always_comb begin
    pipe_valid_d = pipe_valid_q;
    pipe_data_d  = pipe_data_q;
    if (fifo_push) pipe_valid_d = 1'b0;
    if (push) begin
      pipe_valid_d = 1'b1;
      pipe_data_d  = res_data;
    end
    // A new clip wins over a clear on the same edge.
    if (sat_set)      sat_flag_d = 1'b1;
    else if (clr_sat) sat_flag_d = 1'b0;
    else              sat_flag_d = sat_flag_q;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ready_en_q   <= 1'b0;
      pipe_valid_q <= 1'b0;
      pipe_data_q  <= '0;
      sat_flag_q   <= 1'b0;
    end else begin
      ready_en_q   <= 1'b1;
      pipe_valid_q <= pipe_valid_d;
      pipe_data_q  <= pipe_data_d;
      sat_flag_q   <= sat_flag_d;
    end
  end

  assign sat_flag = sat_flag_q;

  fir_sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (FifoDepth)
  ) u_fifo (
    .clk    (clk),
    .nreset (nreset),
    .push   (fifo_push),
    .wdata  (pipe_data_q),
    .pop    (pop),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

`ifdef FIR_REQ_SAT_CNT_EN
  logic [15:0] sat_cnt_q, sat_cnt_d;

  // Clear plus clip on one edge counts that clip, giving 1.
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (clr_sat) begin
      sat_cnt_d = sat_set ? 16'd1 : 16'd0;
    end else if (sat_set && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_d = sat_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) sat_cnt_q <= '0;
    else         sat_cnt_q <= sat_cnt_d;
  end

  assign sat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_fir_out_requant.sv
// Scoreboard bench for fir_out_requant (SHIFT=7, OUT_W=12, DEPTH=4): the driver queues
// hand-computed results as samples are accepted; a negedge monitor pops and compares
// every delivered sample and checks hold stability under backpressure.
module tb_fir_out_requant;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] out_data;
  logic [2:0]  level;
  logic        sat_flag;
  logic        clr_sat = 1'b0;
`ifdef FIR_REQ_SAT_CNT_EN
  logic [15:0] sat_cnt;
`endif

  fir_out_requant #(
    .IN_W  (32),
    .OUT_W (12),
    .SHIFT (7),
    .DEPTH (4)
  ) dut (
    .clk       (clk),
    .nreset    (nreset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level),
    .sat_flag  (sat_flag),
`ifdef FIR_REQ_SAT_CNT_EN
    .sat_cnt   (sat_cnt),
`endif
    .clr_sat   (clr_sat)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [11:0] exp_q[$];
  logic        exp_flag = 1'b0;
  logic [15:0] exp_cnt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares each delivered sample against the scoreboard head.
  logic        hold_v = 1'b0;
  logic [11:0] hold_d = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (!nreset) begin
        hold_v = 1'b0;
        continue;
      end
      if (hold_v && out_valid) chk("hold_stable", 32'(out_data), 32'(hold_d));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_out: got %0h, expected no output", out_data);
        end else begin
          chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end
      hold_v = out_valid && !out_ready;
      hold_d = out_data;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input int data, input int exp, input bit sat);
    int w = 0;
    in_valid = 1'b1;
    in_data  = 32'(data);
    @(negedge clk);
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      chk("send_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back(12'(exp));
    if (sat)          exp_flag = 1'b1;
    else if (clr_sat) exp_flag = 1'b0;
    if (clr_sat)                         exp_cnt = sat ? 16'd1 : 16'd0;
    else if (sat && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    #1;
    in_valid = 1'b0;
    chk("sat_flag", 32'(sat_flag), 32'(exp_flag));
  endtask

  task automatic clear_sat();
    clr_sat = 1'b1;
    @(posedge clk);
    exp_flag = 1'b0;
    exp_cnt  = '0;
    #1;
    clr_sat = 1'b0;
    chk("sat_flag_clr", 32'(sat_flag), 32'(exp_flag));
  endtask

  task automatic drain();
    int w = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && w < 50) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    chk("drain_out_valid", 32'(out_valid), 32'd0);
  endtask

  // Directed vectors: input, expected output (SHIFT=7, +64 then >>>7), saturates.
  int vin [13] = '{320, -320, 64, -64, 63, -65, 262079, -262144, -262145,
                   262080, 1000000, -1000000, 256};
  int vexp[13] = '{3, -2, 1, 0, 0, -1, 2047, -2048, -2048,
                   2047, 2047, -2048, 2};
  bit vsat[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,
                   1, 1, 1, 0};

  initial begin
    int acc;
    bit take;

    // Reset values.
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_sat_flag", 32'(sat_flag), 32'd0);
    #4;
    nreset = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_up", 32'(in_ready), 32'd1);

    // Arithmetic: rounding, boundaries, saturation.
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) send(vin[i], vexp[i], vsat[i]);
    // Clear on the same edge as a clipping push: set wins.
    clr_sat = 1'b1;
    send(-262209, -2048, 1'b1);
    clr_sat = 1'b0;
    clear_sat();
    send(320, 3, 1'b0);
    drain();

`ifdef FIR_REQ_SAT_CNT_EN
    chk("sat_cnt_clr", 32'(sat_cnt), 32'(exp_cnt));
    for (int i = 0; i < 5; i++) send(1000000, 2047, 1'b1);
    chk("sat_cnt_5", 32'(sat_cnt), 32'd5);
    clear_sat();
    chk("sat_cnt_0", 32'(sat_cnt), 32'd0);
    for (int i = 0; i < 65540; i++) send(-1000000, -2048, 1'b1);
    chk("sat_cnt_max", 32'(sat_cnt), 32'hFFFF);
    drain();
    clear_sat();
`endif

    // Latency: accepted at edge k, visible after edge k+1.
    send(vin[12], vexp[12], vsat[12]);
    chk("lat_k", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("lat_k1", 32'(out_valid), 32'd1);
    drain();

    // Backpressure: only DEPTH samples accepted.
    out_ready = 1'b0;
    acc = 0;
    for (int i = 1; i <= 6; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(i * 128);
      @(negedge clk);
      take = in_ready;
      @(posedge clk);
      if (take) begin
        exp_q.push_back(12'(i));
        acc++;
      end
      #1;
    end
    in_valid = 1'b0;
    chk("bp_accepted", 32'(acc), 32'd4);
    chk("bp_level", 32'(level), 32'd4);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    // Full with a pop on the same edge: no push may happen.
    in_valid  = 1'b1;
    in_data   = 32'(99 * 128);
    out_ready = 1'b1;
    @(negedge clk);
    chk("fullpop_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("fullpop_level", 32'(level), 32'd3);
    drain();

    // Asynchronous reset with samples buffered.
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) send(i * 128, i, 1'b0);
    chk("pre_rst_level", 32'(level), 32'd3);
    #2;
    nreset = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    exp_flag = 1'b0;
    exp_cnt  = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    nreset    = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("post_rst_idle", 32'(out_valid), 32'd0);
    end
    send(5 * 128, 5, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
